// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the hazard controller (forward selects, memory FSM states)
package riscv_pkg;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } forward_sel_t;
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: picks the bypass source for one execute-stage operand; the memory stage wins over writeback
module forward_unit
  import riscv_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       reg_write_m,
  input  logic [4:0] rd_m,
  input  logic       reg_write_w,
  input  logic [4:0] rd_w,
  output logic [1:0] fwd
);
  forward_sel_t sel;
  always_comb begin
    sel = (reg_write_m && rd_m != 5'd0 && rd_m == rs) ? FWD_MEM :
          (reg_write_w && rd_w != 5'd0 && rd_w == rs) ? FWD_WB  : FWD_RF;
    fwd = sel;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, load-use/branch hazards and data-memory wait handling
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      Rs1E,
  input  logic [4:0]      Rs2E,
  input  logic [4:0]      RdE,
  input  logic            LoadE,
  input  logic            PCSrcE,
  input  logic            RegWriteM,
  input  logic [4:0]      RdM,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic            MemAccessM,
  input  logic            DMemReady,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushW,
  output logic            DMemReq,
  output logic [XLEN-1:0] StallCount
);
  mem_state_t state, nxt;
  logic mem_stall, load_use;
  forward_unit u_fwd_a (
    .rs(Rs1E), .reg_write_m(RegWriteM), .rd_m(RdM),
    .reg_write_w(RegWriteW), .rd_w(RdW), .fwd(ForwardAE)
  );
  forward_unit u_fwd_b (
    .rs(Rs2E), .reg_write_m(RegWriteM), .rd_m(RdM),
    .reg_write_w(RegWriteW), .rd_w(RdW), .fwd(ForwardBE)
  );
  always_ff @(posedge clk) begin
    state      <= reset ? IDLE : nxt;
    StallCount <= reset ? '0 :
                  ((StallF || StallD || StallE || StallM) && StallCount != '1) ? StallCount + XLEN'(1) :
                  StallCount;
  end
  // An outstanding access keeps waiting exactly while the memory is not ready
  always_comb begin
    mem_stall = !reset && ((state == WAIT) || MemAccessM) && !DMemReady;
    nxt       = mem_stall ? WAIT : IDLE;
    load_use  = LoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    DMemReq   = !reset && ((state == WAIT) || MemAccessM);
    StallF    = !reset && (load_use || mem_stall);
    StallD    = StallF;
    StallE    = mem_stall;
    StallM    = mem_stall;
    FlushW    = mem_stall;
    FlushD    = !reset && !mem_stall && PCSrcE;
    FlushE    = !reset && !mem_stall && (PCSrcE || load_use);
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus checked against a rule-level reference model
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic LoadE, PCSrcE, RegWriteM, RegWriteW, MemAccessM, DMemReady;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, DMemReq;
  logic [3:0] StallCount;
  int errors = 0;
  int checks = 0;
  bit pending = 0;
  int count = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.XLEN(4)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .LoadE(LoadE), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .RdM(RdM),
    .RegWriteW(RegWriteW), .RdW(RdW), .MemAccessM(MemAccessM), .DMemReady(DMemReady),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .DMemReq(DMemReq), .StallCount(StallCount)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction
  task automatic clear();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {LoadE, PCSrcE, RegWriteM, RegWriteW, MemAccessM} = '0;
    DMemReady = 1'b1;
    reset = 1'b0;
  endtask
  // Check every output against the model for the current inputs, then advance one clock
  task automatic cyc(input string tag);
    bit ms, lu, any;
    #1;
    ms  = !reset && (pending || MemAccessM) && !DMemReady;
    lu  = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    any = !reset && (ms || lu);
    chk({tag, ".fwdA"}, 32'(ForwardAE), 32'(fwd_model(Rs1E)));
    chk({tag, ".fwdB"}, 32'(ForwardBE), 32'(fwd_model(Rs2E)));
    chk({tag, ".stallF"}, 32'(StallF), 32'(any));
    chk({tag, ".stallD"}, 32'(StallD), 32'(any));
    chk({tag, ".stallE"}, 32'(StallE), 32'(ms));
    chk({tag, ".stallM"}, 32'(StallM), 32'(ms));
    chk({tag, ".flushW"}, 32'(FlushW), 32'(ms));
    chk({tag, ".flushD"}, 32'(FlushD), 32'(!reset && !ms && PCSrcE));
    chk({tag, ".flushE"}, 32'(FlushE), 32'(!reset && !ms && (PCSrcE || lu)));
    chk({tag, ".dmemreq"}, 32'(DMemReq), 32'(!reset && (pending || MemAccessM)));
    chk({tag, ".count"}, 32'(StallCount), 32'(count));
    @(posedge clk);
    if (reset) begin
      pending = 0;
      count = 0;
    end else begin
      pending = ms;
      if (any && count < 15) count++;
    end
    @(negedge clk);
  endtask
  initial begin
    clear();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc("reset");
    reset = 1'b0;
    cyc("idle");
    // Forwarding priority
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5;
    cyc("fwd_mem");
    chk("fwd_mem.const", 32'(ForwardAE), 32'h2);
    RdM = 0;
    cyc("fwd_wb");
    chk("fwd_wb.const", 32'(ForwardAE), 32'h1);
    Rs1E = 0; RdW = 0; Rs2E = 5; RdM = 5;
    cyc("fwd_zero");
    chk("fwd_zero.const", 32'(ForwardAE), 32'h0);
    clear();
    // Load-use
    LoadE = 1; RdE = 7; Rs2D = 7;
    #1 chk("lu.stallF", 32'(StallF), 32'h1);
    chk("lu.flushE", 32'(FlushE), 32'h1);
    cyc("lu");
    RdE = 0;
    #1 chk("lu_x0.stallF", 32'(StallF), 32'h0);
    cyc("lu_x0");
    clear();
    reset = 1; cyc("rst2"); reset = 0;
    // Three wait cycles then ready
    MemAccessM = 1; DMemReady = 0;
    cyc("mem0"); MemAccessM = 0; cyc("mem1"); cyc("mem2");
    DMemReady = 1;
    #1 chk("mem3.dmemreq", 32'(DMemReq), 32'h1);
    chk("mem3.stallE", 32'(StallE), 32'h0);
    cyc("mem3");
    cyc("mem_done");
    chk("mem.count3", 32'(StallCount), 32'h3);
    chk("mem.reqlow", 32'(DMemReq), 32'h0);
    // Branch during a memory wait
    MemAccessM = 1; DMemReady = 0; PCSrcE = 1; LoadE = 1; RdE = 3; Rs1D = 3;
    #1 chk("br_wait.flushD", 32'(FlushD), 32'h0);
    cyc("br_wait0"); MemAccessM = 0; cyc("br_wait1");
    DMemReady = 1; cyc("br_release");
    #1 chk("br_after.flushD", 32'(FlushD), 32'h1);
    chk("br_after.flushE", 32'(FlushE), 32'h1);
    chk("br_after.stallF", 32'(StallF), 32'h1);
    cyc("br_after");
    clear();
    // Reset mid-wait
    MemAccessM = 1; DMemReady = 0;
    cyc("rw0"); MemAccessM = 0; cyc("rw1");
    reset = 1; cyc("rw_reset"); reset = 0;
    #1 chk("rw.dmemreq", 32'(DMemReq), 32'h0);
    chk("rw.stallM", 32'(StallM), 32'h0);
    chk("rw.count", 32'(StallCount), 32'h0);
    cyc("rw_after");
    // Saturation at 15
    MemAccessM = 1; DMemReady = 0;
    for (int i = 0; i < 18; i++) cyc("sat");
    chk("sat.count15", 32'(StallCount), 32'hf);
    clear();
    cyc("sat_rel");
    reset = 1; cyc("rst3"); reset = 0;
    // Random traffic over a small register range so matches are frequent
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3));
      RdW = 5'($urandom_range(0, 3));
      LoadE = 1'($urandom); PCSrcE = 1'($urandom); RegWriteM = 1'($urandom);
      RegWriteW = 1'($urandom); MemAccessM = 1'($urandom);
      DMemReady = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 39) == 0);
      cyc("rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
